// File: rtl/stage_elastic_pkg.sv
// Shared types and width helpers for the elastic
// stage buffer between tag-check and network/host.
package stage_elastic_pkg;

    localparam int OPC_W  = 2;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;

    typedef struct packed {
        logic [OPC_W-1:0]        opcode;
        logic                    soft_error;
        logic [DATA_W-1:0]       tx_data;
        logic [TAG_W-1:0]        tx_tag;
        logic                    tag_match;
        logic [DATA_W+TAG_W-1:0] ndt;
    } payload_t;

    function automatic int payload_width(int ds, int ts);
        return 2 * (ds + ts) + OPC_W + 2;
    endfunction

endpackage

// File: rtl/stage_elastic_mem.sv
// Payload storage: DEPTH x WIDTH registers,
// one synchronous write port, one async read port.
module stage_elastic_mem #(
    parameter int WIDTH = 84,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stage_elastic.sv
// Elastic DEPTH-entry stage buffer with flush,
// occupancy and a saturating soft-error counter.
module stage_elastic
    import stage_elastic_pkg::*;
#(
    parameter int data_size = 32,
    parameter int tag_size  = 8,
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPC_W-1:0]              opcode_in,
    input  logic                          soft_error_in,
    input  logic [data_size-1:0]          tx_data_in,
    input  logic [tag_size-1:0]           tx_tag_in,
    input  logic                          tag_match_in,
    input  logic [data_size+tag_size-1:0] ndt_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OPC_W-1:0]              opcode_out,
    output logic                          soft_error_out,
    output logic [data_size-1:0]          tx_data_out,
    output logic [tag_size-1:0]           tx_tag_out,
    output logic                          tag_match_out,
    output logic [data_size+tag_size-1:0] ndt_out,
    output logic [data_size-1:0]          rx_data,
    output logic [data_size+tag_size-1:0] tx_data_plus_tag,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [CNT_WIDTH-1:0]          soft_err_count
);

    localparam int PW = payload_width(data_size, tag_size);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int NW = data_size + tag_size;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic          push;
    logic          pop;
    logic [PW-1:0] wdata;
    logic [PW-1:0] rdata;
    logic [PW-1:0] head;

    assign in_ready  = (count != OW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = count;

    assign wdata = {opcode_in, soft_error_in, tx_data_in,
                    tx_tag_in, tag_match_in, ndt_in};

    stage_elastic_mem #(
        .WIDTH (PW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + OW'(push) - OW'(pop);
        end
    end

    // Counts accepted pushes even if a flush discards them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            soft_err_count <= '0;
        end else if (push && soft_error_in && soft_err_count != '1) begin
            soft_err_count <= soft_err_count + CNT_WIDTH'(1);
        end
    end

    assign head = out_valid ? rdata : '0;

    assign {opcode_out, soft_error_out, tx_data_out,
            tx_tag_out, tag_match_out, ndt_out} = head;

    assign rx_data          = ndt_out[NW-1:tag_size];
    assign tx_data_plus_tag = {tx_data_out, tx_tag_out};

endmodule
